// File: rtl/ser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ser_pkg
// Brief    : Shared state encoding and default frame constants for the serial link.
// Revision : 1.0
// ============================================================================
package ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } ser_state_e;

   localparam int c_data_w  = 8;
   localparam int c_bit_cyc = 4;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ser_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : ser_bit_timer
// Brief    : Enabled modulo-BIT_CYC cycle counter; tick marks the rollover cycle.
// Revision : 1.0
// ============================================================================
module ser_bit_timer
   import ser_pkg::*;
#(
   parameter int BIT_CYC = c_bit_cyc
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tick
);

   localparam int                c_cnt_w = cnt_width(BIT_CYC);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIT_CYC - 1);

   logic [c_cnt_w-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (en) begin
         if (r_cnt == c_last) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign tick = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/ser_tx.sv
`default_nettype none
// ============================================================================
// Module   : ser_tx
// Brief    : Serial frame transmitter: start bit, DATA_W bits LSB first, stop bit.
// Revision : 1.0
// ============================================================================
module ser_tx
   import ser_pkg::*;
#(
   parameter int DATA_W  = c_data_w,
   parameter int BIT_CYC = c_bit_cyc
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              txd,
   output logic              busy
);

   localparam int                c_bit_w    = cnt_width(DATA_W);
   localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_W - 1);

   ser_state_e          r_state,    w_state;
   logic [DATA_W-1:0]   r_shift,    w_shift;
   logic [c_bit_w-1:0]  r_bit_idx,  w_bit_idx;
   logic                r_txd,      w_txd;
   logic                r_tx_ready, w_tx_ready;
   logic                r_busy,     w_busy;
   logic                w_timer_en;
   logic                w_tick;

   // The timer only runs inside a frame so every frame starts from count 0.
   assign w_timer_en = en && (r_state != IDLE);

   ser_bit_timer #(
      .BIT_CYC (BIT_CYC)
   ) u_bit_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (w_timer_en),
      .tick    (w_tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_txd      <= 1'b1;
         r_tx_ready <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_shift    <= w_shift;
         r_bit_idx  <= w_bit_idx;
         r_txd      <= w_txd;
         r_tx_ready <= w_tx_ready;
         r_busy     <= w_busy;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_shift    = r_shift;
      w_bit_idx  = r_bit_idx;
      w_txd      = r_txd;
      w_tx_ready = r_tx_ready;
      w_busy     = r_busy;
      case (r_state)
         IDLE: begin
            if (en && tx_valid) begin
               w_shift    = tx_data;
               w_bit_idx  = '0;
               w_state    = START;
               w_txd      = 1'b0;
               w_tx_ready = 1'b0;
               w_busy     = 1'b1;
            end
         end
         START: begin
            if (w_tick) begin
               w_state = DATA;
               w_txd   = r_shift[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift = r_shift >> 1;
               if (r_bit_idx == c_last_bit) begin
                  w_state   = STOP;
                  w_bit_idx = '0;
                  w_txd     = 1'b1;
               end else begin
                  w_bit_idx = r_bit_idx + 1'b1;
                  w_txd     = w_shift[0];
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               w_state    = IDLE;
               w_txd      = 1'b1;
               w_tx_ready = 1'b1;
               w_busy     = 1'b0;
            end
         end
      endcase
   end

   assign txd      = r_txd;
   assign tx_ready = r_tx_ready;
   assign busy     = r_busy;

endmodule
`default_nettype wire
